fifo_flag_ctrl: RTL

- Registered pointer and flag controller for the synchronous FIFO.
- Owns the write/read addresses and an explicit occupancy counter, and drives memory enables plus registered status flags.
- Supports any depth ≥ 2, including non-power-of-two depths, with programmable almost-full/almost-empty levels, synchronous flush, and sticky overflow/underflow error flags.
- Sits between the FIFO's stream handshake ports and its dual-port memory.

---
 rtl/fifo_flag_ctrl.sv | 105 ++++++++++
 1 files changed

// File: rtl/fifo_flag_ctrl.sv
// Pointer, occupancy and status-flag controller for a synchronous FIFO.
// Works for any depth >= 2; pointers wrap explicitly rather than relying on binary rollover.
module fifo_flag_ctrl #(
  parameter int FIFO_DEPTH = 16,
  parameter int ADDR_WIDTH = $clog2(FIFO_DEPTH),
  parameter int CNT_WIDTH  = $clog2(FIFO_DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_valid_s,
  input  logic                  i_ready_m,
  input  logic                  i_flush,
  input  logic                  i_clr_err,
  input  logic [CNT_WIDTH-1:0]  i_almostfull_lvl,
  input  logic [CNT_WIDTH-1:0]  i_almostempty_lvl,
  output logic                  o_wr_en,
  output logic [ADDR_WIDTH-1:0] o_wr_addr,
  output logic                  o_rd_en,
  output logic [ADDR_WIDTH-1:0] o_rd_addr,
  output logic [CNT_WIDTH-1:0]  o_count,
  output logic                  o_ready_s,
  output logic                  o_valid_m,
  output logic                  o_full,
  output logic                  o_empty,
  output logic                  o_almostfull,
  output logic                  o_almostempty,
  output logic                  o_overflow,
  output logic                  o_underflow
);

  typedef enum logic [1:0] {EMPTY, PARTIAL, FULL} state_t;

  localparam logic [CNT_WIDTH-1:0]  DEPTH_CNT = CNT_WIDTH'(FIFO_DEPTH);
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(FIFO_DEPTH - 1);

  state_t                state, next_state;
  logic [ADDR_WIDTH-1:0] wr_ptr, rd_ptr, wr_ptr_nxt, rd_ptr_nxt;
  logic [CNT_WIDTH-1:0]  next_count;

  assign o_wr_en   = i_valid_s & ~o_full  & ~i_flush;
  assign o_rd_en   = i_ready_m & ~o_empty & ~i_flush;
  assign o_wr_addr = wr_ptr;
  assign o_rd_addr = rd_ptr;
  assign o_ready_s = ~o_full;
  assign o_valid_m = ~o_empty;

  always_comb begin
    wr_ptr_nxt = wr_ptr;
    rd_ptr_nxt = rd_ptr;
    next_count = o_count;
    next_state = state;
    if (i_flush) begin
      wr_ptr_nxt = '0;
      rd_ptr_nxt = '0;
      next_count = '0;
      next_state = EMPTY;
    end else begin
      if (o_wr_en)
        wr_ptr_nxt = (wr_ptr == LAST_ADDR) ? '0 : wr_ptr + ADDR_WIDTH'(1);
      if (o_rd_en)
        rd_ptr_nxt = (rd_ptr == LAST_ADDR) ? '0 : rd_ptr + ADDR_WIDTH'(1);
      if (o_wr_en && !o_rd_en)
        next_count = o_count + CNT_WIDTH'(1);
      else if (o_rd_en && !o_wr_en)
        next_count = o_count - CNT_WIDTH'(1);
      case (state)
        EMPTY:   if (o_wr_en) next_state = PARTIAL;
        PARTIAL: begin
          if (next_count == DEPTH_CNT)  next_state = FULL;
          else if (next_count == '0)    next_state = EMPTY;
        end
        FULL:    if (o_rd_en) next_state = PARTIAL;
        default: next_state = EMPTY;
      endcase
    end
  end

  // Flags are registered from next_count/next_state so they line up with o_count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= EMPTY;
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      o_count       <= '0;
      o_full        <= 1'b0;
      o_empty       <= 1'b1;
      o_almostfull  <= 1'b0;
      o_almostempty <= 1'b1;
      o_overflow    <= 1'b0;
      o_underflow   <= 1'b0;
    end else begin
      state         <= next_state;
      wr_ptr        <= wr_ptr_nxt;
      rd_ptr        <= rd_ptr_nxt;
      o_count       <= next_count;
      o_full        <= (next_state == FULL);
      o_empty       <= (next_state == EMPTY);
      o_almostfull  <= (next_count >= i_almostfull_lvl);
      o_almostempty <= (next_count <= i_almostempty_lvl);
      o_overflow    <= (i_valid_s & o_full)  | (o_overflow  & ~i_clr_err);
      o_underflow   <= (i_ready_m & o_empty) | (o_underflow & ~i_clr_err);
    end
  end

endmodule
